// File: rtl/cic_decimator.sv
// rtl/cic_decimator.sv - N-stage CIC decimator (integrators, decimate by R, combs, scaling)
// Define CIC_ROUND_EN for round-half-up with saturation on the output scaling.
module cic_decimator #(
   parameter int IN_WIDTH          = 16,
   parameter int OUT_WIDTH         = 16,
   parameter int DECIMATION_FACTOR = 4,
   parameter int NUM_STAGES        = 3,
   parameter int DIFF_DELAY        = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   input  logic signed [IN_WIDTH-1:0]  in_data,
   output logic                        out_valid,
   output logic signed [OUT_WIDTH-1:0] out_data
);
   localparam int ACC_WIDTH = IN_WIDTH + NUM_STAGES * $clog2(DECIMATION_FACTOR * DIFF_DELAY);
   localparam int DROP      = ACC_WIDTH - OUT_WIDTH;
   localparam int CNT_W     = $clog2(DECIMATION_FACTOR);
   localparam logic [CNT_W-1:0] LAST_PHASE = CNT_W'(DECIMATION_FACTOR - 1);

   logic signed [ACC_WIDTH-1:0] in_ext;
   logic signed [ACC_WIDTH-1:0] integ_q [NUM_STAGES];
   logic [CNT_W-1:0]            phase_q, phase_d;
   logic                        dec_q;
   logic signed [ACC_WIDTH-1:0] comb_q  [NUM_STAGES];
   logic signed [ACC_WIDTH-1:0] comb_in [NUM_STAGES];
   logic signed [ACC_WIDTH-1:0] dly_q   [NUM_STAGES][DIFF_DELAY];
   logic [NUM_STAGES-1:0]       stage_en, cvalid_q;
   logic signed [ACC_WIDTH-1:0] comb_out;
   logic signed [OUT_WIDTH-1:0] scaled;
   logic signed [OUT_WIDTH-1:0] out_data_q, out_data_d;
   logic                        out_valid_q;

   assign in_ext = ACC_WIDTH'(in_data);

   // Wrapping adders are intentional: the combs cancel integrator overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NUM_STAGES; k++) integ_q[k] <= '0;
      end else if (in_valid) begin
         integ_q[0] <= integ_q[0] + in_ext;
         for (int k = 1; k < NUM_STAGES; k++) integ_q[k] <= integ_q[k] + integ_q[k-1];
      end
   end

   always_comb begin
      phase_d = phase_q;
      if (in_valid) phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q <= '0;
         dec_q   <= 1'b0;
      end else begin
         phase_q <= phase_d;
         dec_q   <= in_valid && (phase_q == LAST_PHASE);
      end
   end

   always_comb begin
      stage_en[0] = dec_q;
      comb_in[0]  = integ_q[NUM_STAGES-1];
      for (int k = 1; k < NUM_STAGES; k++) begin
         stage_en[k] = cvalid_q[k-1];
         comb_in[k]  = comb_q[k-1];
      end
   end

   // Each comb stage fires one cycle after its predecessor; delay lines move only then.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cvalid_q <= '0;
         for (int k = 0; k < NUM_STAGES; k++) begin
            comb_q[k] <= '0;
            for (int m = 0; m < DIFF_DELAY; m++) dly_q[k][m] <= '0;
         end
      end else begin
         cvalid_q <= stage_en;
         for (int k = 0; k < NUM_STAGES; k++) begin
            if (stage_en[k]) begin
               comb_q[k]   <= comb_in[k] - dly_q[k][DIFF_DELAY-1];
               dly_q[k][0] <= comb_in[k];
               for (int m = 1; m < DIFF_DELAY; m++) dly_q[k][m] <= dly_q[k][m-1];
            end
         end
      end
   end

   assign comb_out = comb_q[NUM_STAGES-1];

   generate
      if (DROP > 0) begin : g_drop
`ifdef CIC_ROUND_EN
         localparam logic [ACC_WIDTH:0] HALF = (ACC_WIDTH + 1)'(1) << (DROP - 1);
         logic [ACC_WIDTH:0] rnd;
         logic [OUT_WIDTH:0] shr;
         // One guard bit so the rounding add cannot wrap before the saturation test.
         assign rnd    = {comb_out[ACC_WIDTH-1], comb_out} + HALF;
         assign shr    = (OUT_WIDTH + 1)'(rnd >> DROP);
         assign scaled = (shr[OUT_WIDTH] != shr[OUT_WIDTH-1])
                       ? {shr[OUT_WIDTH], {(OUT_WIDTH-1){~shr[OUT_WIDTH]}}}
                       : shr[OUT_WIDTH-1:0];
`else
         assign scaled = OUT_WIDTH'(comb_out >> DROP);
`endif
      end else begin : g_ext
         assign scaled = OUT_WIDTH'(comb_out);
      end
   endgenerate

   always_comb begin
      out_data_d = out_data_q;
      if (cvalid_q[NUM_STAGES-1]) out_data_d = scaled;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= cvalid_q[NUM_STAGES-1];
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
endmodule

// File: tb/tb_cic_decimator.sv
// tb/tb_cic_decimator.sv - directed vector bench for cic_decimator (N=3, R=4, M=1)
// Expected outputs follow CIC_ROUND_EN when the bench is built with it defined.
module tb_cic_decimator;
   logic                clk = 1'b0;
   logic                reset;
   logic                in_valid;
   logic signed [15:0]  in_data;
   logic                out_valid;
   logic signed [15:0]  out_data;

   cic_decimator #(
      .IN_WIDTH(16), .OUT_WIDTH(16), .DECIMATION_FACTOR(4), .NUM_STAGES(3), .DIFF_DELAY(1)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .out_valid(out_valid), .out_data(out_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int outs[$];
   int out_cyc[$];
   int acc_cyc[$];
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         outs.push_back(int'(out_data));
         out_cyc.push_back(cyc);
      end
   end

   typedef struct packed {
      logic signed [31:0]      first;
      logic signed [31:0]      rest;
      logic [5:0][31:0]        exp;
   } vec_t;

   vec_t vecs [6];
   int   passed = 0;
   int   total  = 0;

   function automatic vec_t mk(int f, int r, int e0, int e1, int e2, int e3, int e4, int e5);
      vec_t v;
      v.first  = f;
      v.rest   = r;
      v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2;
      v.exp[3] = e3; v.exp[4] = e4; v.exp[5] = e5;
      return v;
   endfunction

   task automatic check(string name, int act, int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int got(int k);
      return (k < outs.size()) ? outs[k] : -999999;
   endfunction

   function automatic int lat(int ko, int ka);
      if (ko >= out_cyc.size() || ka >= acc_cyc.size()) return -999999;
      return out_cyc[ko] - acc_cyc[ka];
   endfunction

   task automatic clear_logs();
      outs.delete();
      out_cyc.delete();
      acc_cyc.delete();
   endtask

   task automatic feed(int first, int rest, int n, bit gap);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 16'((i == 0) ? first : rest);
         acc_cyc.push_back(cyc + 1);
         if (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'sd5000;
      repeat (3) @(negedge clk);
      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      clear_logs();
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;

`ifdef CIC_ROUND_EN
      vecs[0] = mk(1000, 1000, 63, 688, 1000, 1000, 1000, 1000);
      vecs[3] = mk(32767, 32767, 2048, 22527, 32767, 32767, 32767, 32767);
      vecs[5] = mk(4, 0, 0, 1, 0, 0, 0, 0);
`else
      vecs[0] = mk(1000, 1000, 62, 687, 1000, 1000, 1000, 1000);
      vecs[3] = mk(32767, 32767, 2047, 22527, 32767, 32767, 32767, 32767);
      vecs[5] = mk(4, 0, 0, 0, 0, 0, 0, 0);
`endif
      vecs[1] = mk(1024, 0, 48, 192, 16, 0, 0, 0);
      vecs[2] = mk(-1024, 0, -48, -192, -16, 0, 0, 0);
      vecs[4] = mk(-32768, -32768, -2048, -22528, -32768, -32768, -32768, -32768);

      #12;
      check("reset out_valid", int'(out_valid), 0);
      check("reset out_data", int'(out_data), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      for (int v = 0; v < 6; v++) begin
         do_reset();
         feed(vecs[v].first, vecs[v].rest, 24, 1'b0);
         repeat (8) @(negedge clk);
         check($sformatf("vec%0d count", v), outs.size(), 6);
         check($sformatf("vec%0d latency", v), lat(0, 3), 4);
         for (int j = 0; j < 6; j++)
            check($sformatf("vec%0d out%0d", v, j), got(j), int'($signed(vecs[v].exp[j])));
      end

      // Alternate-cycle input: period stretches to 8, latency stays N+1.
      do_reset();
      feed(1000, 1000, 16, 1'b1);
      repeat (8) @(negedge clk);
      check("gap count", outs.size(), 4);
      for (int k = 0; k < 4; k++) check($sformatf("gap latency%0d", k), lat(k, 4 * k + 3), 4);
      for (int k = 0; k < 3; k++)
         check($sformatf("gap period%0d", k),
               (k + 1 < out_cyc.size()) ? out_cyc[k+1] - out_cyc[k] : -999999, 8);
      check("gap out2", got(2), 1000);
      check("gap out3", got(3), 1000);

      // Full-scale step across integrator wrap.
      do_reset();
      feed(32767, 32767, 32, 1'b0);
      feed(-32768, -32768, 32, 1'b0);
      repeat (8) @(negedge clk);
      check("fs count", outs.size(), 16);
      check("fs pos settled", got(7), 32767);
      for (int k = 12; k < 16; k++) check($sformatf("fs neg%0d", k), got(k), -32768);

      // Asynchronous reset mid-stream, two samples into a block.
      do_reset();
      feed(1000, 1000, 10, 1'b0);
      check("pre-reset hold", int'(out_data), vecs[0].exp[0]);
      #2 reset = 1'b1;
      #1;
      check("async rst out_valid", int'(out_valid), 0);
      check("async rst out_data", int'(out_data), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      clear_logs();
      feed(0, 0, 3, 1'b0);
      repeat (8) @(negedge clk);
      check("no early output", outs.size(), 0);
      feed(0, 0, 1, 1'b0);
      repeat (8) @(negedge clk);
      check("post-reset count", outs.size(), 1);
      check("post-reset data", got(0), 0);
      check("post-reset latency", lat(0, 3), 4);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
